// File: rtl/video_timing_gen.sv
// Raster timing source: pixel divider, h/v counters, sync/vde/marker outputs.
// Optional macro VIDEO_TIMING_GEN_PIPE_ALIGN_EN delays hsync/vsync/vde by PIPE_STAGES ticks.
module video_timing_gen #(
   parameter int H_VISIBLE   = 640,
   parameter int H_FRONT     = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int V_VISIBLE   = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter int CLK_DIV     = 1,
   parameter int SYNC_POL    = 0,
   parameter int PIPE_STAGES = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       run,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       hsync,
   output logic       vsync,
   output logic       vde,
   output logic       pix_en,
   output logic       line_end,
   output logic       frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic       S_ACT    = (SYNC_POL != 0);
   localparam logic       S_IDLE   = ~S_ACT;

   generate
      if (CLK_DIV < 1 || CLK_DIV > 8 || PIPE_STAGES < 0 || PIPE_STAGES > 4) begin : g_bad_param
         $error("video_timing_gen: CLK_DIV must be 1..8 and PIPE_STAGES 0..4");
      end
   endgenerate

   function automatic logic sync_level(input logic active);
      return active ? S_ACT : S_IDLE;
   endfunction

   logic [2:0] div, div_nxt;
   logic [9:0] hc, vc, hc_nxt, vc_nxt;
   logic       hs_p0, vs_p0, vde_p0;

   always_comb begin
      pix_en  = run && !Reset && (div == DIV_LAST);
      div_nxt = div;
      hc_nxt  = hc;
      vc_nxt  = vc;
      if (run) begin
         div_nxt = (div == DIV_LAST) ? 3'd0 : div + 3'd1;
      end
      if (pix_en) begin
         if (hc == H_LAST) begin
            hc_nxt = 10'd0;
            vc_nxt = (vc == V_LAST) ? 10'd0 : vc + 10'd1;
         end else begin
            hc_nxt = hc + 10'd1;
         end
      end
   end

   // Stage p0: counters plus levels decoded from the next-state counters
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         div         <= 3'd0;
         hc          <= 10'd0;
         vc          <= 10'd0;
         vde_p0      <= 1'b0;
         hs_p0       <= S_IDLE;
         vs_p0       <= S_IDLE;
         line_end    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         div         <= div_nxt;
         hc          <= hc_nxt;
         vc          <= vc_nxt;
         line_end    <= pix_en && (hc == H_LAST);
         frame_start <= pix_en && (hc_nxt == 10'd0) && (vc_nxt == V_VIS);
         // Levels freeze while run is low so a paused raster stays stable.
         if (run) begin
            vde_p0 <= (hc_nxt < H_VIS) && (vc_nxt < V_VIS);
            hs_p0  <= sync_level((hc_nxt >= HS_FIRST) && (hc_nxt < HS_END));
            vs_p0  <= sync_level((vc_nxt >= VS_FIRST) && (vc_nxt < VS_END));
         end
      end
   end

   assign DrawX = hc;
   assign DrawY = vc;

`ifdef VIDEO_TIMING_GEN_PIPE_ALIGN_EN
   generate
      if (PIPE_STAGES == 0) begin : g_no_pipe
         assign hsync = hs_p0;
         assign vsync = vs_p0;
         assign vde   = vde_p0;
      end else begin : g_pipe
         logic [PIPE_STAGES-1:0] hs_p1, vs_p1, vde_p1;

         // Stage p1: tick-advanced delay line matching the color-mapper depth
         always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
               hs_p1  <= {PIPE_STAGES{S_IDLE}};
               vs_p1  <= {PIPE_STAGES{S_IDLE}};
               vde_p1 <= '0;
            end else if (pix_en) begin
               hs_p1[0]  <= hs_p0;
               vs_p1[0]  <= vs_p0;
               vde_p1[0] <= vde_p0;
               for (int i = 1; i < PIPE_STAGES; i++) begin
                  hs_p1[i]  <= hs_p1[i-1];
                  vs_p1[i]  <= vs_p1[i-1];
                  vde_p1[i] <= vde_p1[i-1];
               end
            end
         end

         assign hsync = hs_p1[PIPE_STAGES-1];
         assign vsync = vs_p1[PIPE_STAGES-1];
         assign vde   = vde_p1[PIPE_STAGES-1];
      end
   endgenerate
`else
   assign hsync = hs_p0;
   assign vsync = vs_p0;
   assign vde   = vde_p0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized run/reset bench for video_timing_gen: two instances (CLK_DIV 1 and 3)
// scored against a tick-count reference model through per-instance expectation queues.
module tb_video_timing_gen;

   localparam int HV = 16, HF = 2, HS = 3, HB = 3;
   localparam int VV = 8,  VF = 1, VS = 2, VB = 2;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int PS = 2;
   localparam int NCYC = 7000;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       de;
      logic       pe;
      logic       le;
      logic       fs;
   } obs_t;

   logic       clk = 1'b0;
   logic       Reset = 1'b1;
   logic       run = 1'b0;
   logic [9:0] x1, y1, x3, y3;
   logic       hs1, vs1, de1, pe1, le1, fs1;
   logic       hs3, vs3, de3, pe3, le3, fs3;

   int checks = 0;
   int passed = 0;
   obs_t q [2][$];

   video_timing_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .CLK_DIV(1), .SYNC_POL(0), .PIPE_STAGES(PS)
   ) u_d1 (
      .Clk(clk), .Reset(Reset), .run(run), .DrawX(x1), .DrawY(y1),
      .hsync(hs1), .vsync(vs1), .vde(de1), .pix_en(pe1),
      .line_end(le1), .frame_start(fs1)
   );

   video_timing_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .CLK_DIV(3), .SYNC_POL(1), .PIPE_STAGES(PS)
   ) u_d3 (
      .Clk(clk), .Reset(Reset), .run(run), .DrawX(x3), .DrawY(y3),
      .hsync(hs3), .vsync(vs3), .vde(de3), .pix_en(pe3),
      .line_end(le3), .frame_start(fs3)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
   endtask

   // Reference model: ticks since reset and run-high cycles since reset.
   int   div_of [2] = '{1, 3};
   logic pol_of [2] = '{1'b0, 1'b1};
   int   t [2];
   int   rc [2];
   logic de_u [2], hs_u [2], vs_u [2];
   logic de_d [2][PS], hs_d [2][PS], vs_d [2][PS];
   logic le_m [2], fs_m [2];

   task automatic model_reset(input int k);
      t[k] = 0; rc[k] = 0;
      de_u[k] = 1'b0; hs_u[k] = 1'b0; vs_u[k] = 1'b0;
      le_m[k] = 1'b0; fs_m[k] = 1'b0;
      for (int i = 0; i < PS; i++) begin
         de_d[k][i] = 1'b0; hs_d[k][i] = 1'b0; vs_d[k][i] = 1'b0;
      end
   endtask

   task automatic model_edge(input int k, input logic r);
      logic pix;
      int   old_t, hc, vc;
      pix   = r && (rc[k] % div_of[k] == div_of[k] - 1);
      old_t = t[k];
      if (r) rc[k]++;
      if (pix) begin
         for (int i = PS - 1; i > 0; i--) begin
            de_d[k][i] = de_d[k][i-1]; hs_d[k][i] = hs_d[k][i-1]; vs_d[k][i] = vs_d[k][i-1];
         end
         de_d[k][0] = de_u[k]; hs_d[k][0] = hs_u[k]; vs_d[k][0] = vs_u[k];
         t[k]++;
      end
      hc = t[k] % HT;
      vc = (t[k] / HT) % VT;
      if (r) begin
         de_u[k] = (hc < HV) && (vc < VV);
         hs_u[k] = (hc >= HV + HF) && (hc < HV + HF + HS);
         vs_u[k] = (vc >= VV + VF) && (vc < VV + VF + VS);
      end
      le_m[k] = pix && (old_t % HT == HT - 1);
      fs_m[k] = pix && (hc == 0) && (vc == VV);
   endtask

   function automatic obs_t model_obs(input int k, input logic r, input logic rst);
      obs_t o;
      logic hs_a, vs_a;
      o.x  = 10'(t[k] % HT);
      o.y  = 10'((t[k] / HT) % VT);
`ifdef VIDEO_TIMING_GEN_PIPE_ALIGN_EN
      hs_a = hs_d[k][PS-1]; vs_a = vs_d[k][PS-1]; o.de = de_d[k][PS-1];
`else
      hs_a = hs_u[k]; vs_a = vs_u[k]; o.de = de_u[k];
`endif
      o.hs = hs_a ? pol_of[k] : ~pol_of[k];
      o.vs = vs_a ? pol_of[k] : ~pol_of[k];
      o.pe = !rst && r && (rc[k] % div_of[k] == div_of[k] - 1);
      o.le = le_m[k];
      o.fs = fs_m[k];
      return o;
   endfunction

   // Monitor: every edge each instance presents a new output vector.
   always @(posedge clk) begin
      obs_t a [2];
      #2;
      a[0] = '{x1, y1, hs1, vs1, de1, pe1, le1, fs1};
      a[1] = '{x3, y3, hs3, vs3, de3, pe3, le3, fs3};
      for (int k = 0; k < 2; k++) begin
         if (q[k].size() == 0) begin
            check($sformatf("queue_underflow_d%0d", k), 32'd0, 32'd1);
         end else begin
            check($sformatf("outputs_d%0d", k), 32'(a[k]), 32'(q[k].pop_front()));
         end
      end
   end

   initial begin
      logic r, rst, prev_rst;
      prev_rst = 1'b1;
      for (int k = 0; k < 2; k++) model_reset(k);
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         rst = (cyc < 3) || (cyc >= 3000 && cyc < 3003) || (cyc >= 5200 && cyc < 5202);
         if (cyc >= 1000 && cyc < 1050) r = 1'b0;
         else r = ($urandom_range(0, 99) < 93);
         run   = r;
         Reset = rst;
         if (rst) begin
            if (!prev_rst) begin
               #1;
               check("async_rst_x_d1", 32'(x1), 32'd0);
               check("async_rst_y_d1", 32'(y1), 32'd0);
               check("async_rst_vde_d1", 32'(de1), 32'd0);
               check("async_rst_hs_d1", 32'(hs1), 32'd1);
               check("async_rst_vs_d3", 32'(vs3), 32'd0);
               check("async_rst_x_d3", 32'(x3), 32'd0);
               check("async_rst_y_d3", 32'(y3), 32'd0);
            end
            for (int k = 0; k < 2; k++) model_reset(k);
         end else begin
            for (int k = 0; k < 2; k++) model_edge(k, r);
         end
         for (int k = 0; k < 2; k++) q[k].push_back(model_obs(k, r, rst));
         prev_rst = rst;
         @(negedge clk);
      end
      check("queue_drained_d1", 32'(q[0].size()), 32'd0);
      check("queue_drained_d3", 32'(q[1].size()), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
